// File: rtl/e3_pkg.sv
// Shared Excess-3 definitions for the sequential XS-3 multiplier.
package e3_pkg;

    localparam logic [3:0] XS3_ZERO = 4'b0011;
    localparam logic [3:0] XS3_MIN  = 4'b0011;
    localparam logic [3:0] XS3_MAX  = 4'b1100;

    typedef enum logic [1:0] {IDLE, RUN, DONE, ERR} state_t;

    // A digit code is legal only inside the 0..9 window of XS-3.
    function automatic bit xs3_valid(input logic [3:0] digit);
        return (digit >= XS3_MIN) && (digit <= XS3_MAX);
    endfunction

    // Decimal value of a (valid) XS-3 digit.
    function automatic logic [3:0] xs3_to_int(input logic [3:0] digit);
        return digit - XS3_ZERO;
    endfunction

endpackage

// File: rtl/e3_add.sv
// Combinational multi-digit XS-3 ripple adder; the top-digit carry is dropped.
module e3_add
    import e3_pkg::*;
#(
    parameter int NDIG_ADD = 4
) (
    input  logic [4*NDIG_ADD-1:0] a,
    input  logic [4*NDIG_ADD-1:0] b,
    output logic [4*NDIG_ADD-1:0] sum
);

    // carry[g] is the carry into digit g
    logic [NDIG_ADD-1:0] carry;

    assign carry[0] = 1'b0;

    for (genvar g = 0; g < NDIG_ADD; g++) begin : g_dig
        logic [4:0] raw;

        // Binary add of two XS-3 digits carries a +6 bias; correct it back to +3.
        assign raw = {1'b0, a[4*g +: 4]} + {1'b0, b[4*g +: 4]} + {4'b0, carry[g]};
        assign sum[4*g +: 4] = raw[4] ? raw[3:0] + XS3_ZERO : raw[3:0] - XS3_ZERO;

        if (g < NDIG_ADD - 1) begin : g_chain
            assign carry[g+1] = raw[4];
        end
    end

endmodule

// File: rtl/e3_seq_mult.sv
// Sequential XS-3 multiplier: repeated addition of the shifted multiplicand,
// one multiplier digit at a time, accumulator kept in XS-3 throughout.
module e3_seq_mult
    import e3_pkg::*;
#(
    parameter int NDIG = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [4*NDIG-1:0] in_0,
    input  logic [4*NDIG-1:0] in_1,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [8*NDIG-1:0] out
);

    localparam int OW = 4 * NDIG;
    localparam int PW = 8 * NDIG;
    localparam int JW = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [PW-1:0] PROD_ZERO = {(2*NDIG){XS3_ZERO}};
    localparam logic [JW-1:0] J_LAST    = JW'(NDIG - 1);

    state_t          state;
    logic [OW-1:0]   mcand;
    logic [OW-1:0]   mplier;
    logic [PW-1:0]   acc;
    logic [PW-1:0]   addend;
    logic [PW-1:0]   acc_nxt;
    logic [JW-1:0]   j;
    logic [3:0]      cnt;
    logic [3:0]      next_dig;
    logic            ops_ok;

    // Both operands must consist solely of legal XS-3 digit codes.
    always_comb begin
        ops_ok = 1'b1;
        for (int k = 0; k < NDIG; k++) begin
            if (!xs3_valid(in_0[4*k +: 4]) || !xs3_valid(in_1[4*k +: 4]))
                ops_ok = 1'b0;
        end
    end

    // Multiplicand shifted up j digits; vacated digits hold XS-3 zero.
    always_comb begin
        addend = PROD_ZERO;
        for (int k = 0; k < NDIG; k++)
            addend[4*(k + int'(j)) +: 4] = mcand[4*k +: 4];
    end

    // Multiplier digit j+1, loaded into cnt when moving to the next digit.
    always_comb begin
        next_dig = XS3_ZERO;
        for (int k = 0; k < NDIG; k++) begin
            if (k == int'(j) + 1)
                next_dig = mplier[4*k +: 4];
        end
    end

    e3_add #(.NDIG_ADD(2*NDIG)) u_add (
        .a   (acc),
        .b   (addend),
        .sum (acc_nxt)
    );

    // Control FSM with registered handshake outputs and the datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            err    <= 1'b0;
            out    <= PROD_ZERO;
            acc    <= PROD_ZERO;
            mcand  <= '0;
            mplier <= '0;
            j      <= '0;
            cnt    <= '0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        mcand  <= in_0;
                        mplier <= in_1;
                        busy   <= 1'b1;
                        if (!ops_ok) begin
                            state <= ERR;
                        end else begin
                            state <= RUN;
                            j     <= '0;
                            cnt   <= xs3_to_int(in_1[3:0]);
                            acc   <= PROD_ZERO;
                        end
                    end
                end
                RUN: begin
                    if (cnt != 4'd0) begin
                        acc <= acc_nxt;
                        cnt <= cnt - 4'd1;
                    end else if (j == J_LAST) begin
                        state <= DONE;
                    end else begin
                        j   <= j + 1'b1;
                        cnt <= xs3_to_int(next_dig);
                    end
                end
                DONE: begin
                    out   <= acc;
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                ERR: begin
                    out   <= PROD_ZERO;
                    done  <= 1'b1;
                    err   <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/e3_seq_mult.md
Name: e3_seq_mult

Overview:
- Multi-digit Excess-3 (XS-3) multiplier: NDIG-digit × NDIG-digit operands, 2·NDIG-digit XS-3 product.
- Sequential repeated-addition engine with start/done handshake. One XS-3 addition per cycle, accumulator held natively in XS-3 (no binary conversion).
- Successor to the single-digit combinational XS-3 multiplier. Adds width parametrisation, operand validation and a handshake. Used by the digit-arithmetic datapath where area matters more than latency.

Parameters:
- NDIG, 2, decimal digits per operand (≥1); operand width 4·NDIG, product width 8·NDIG

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- start  input  1  request; accepted only in IDLE
- in_0  input  4·NDIG  multiplicand, XS-3, digit 0 at [3:0]
- in_1  input  4·NDIG  multiplier, XS-3, digit 0 at [3:0]
- busy  output  1  high whenever state ≠ IDLE
- done  output  1  one-cycle pulse, result valid
- err  output  1  qualifies done; 1 = invalid input digit
- out  output  8·NDIG  product, XS-3, held until next done

Behaviour:
- Reset (async, rst_n=0): state=IDLE; busy=0, done=0, err=0, out = all digits 4'b0011 (XS-3 zero). Reset mid-operation aborts immediately; no done is issued.
- Valid XS-3 digit: 4'b0011..4'b1100. Any other code in in_0 or in_1 is invalid.
- IDLE, start=1: latch in_0/in_1 into internal registers; operands may change afterwards.
  - Any invalid digit → ERR.
  - Else → RUN with j=0, cnt = decoded multiplier digit 0, acc = XS-3 zero.
- IDLE, start=0: no state change.
- RUN, cnt≠0: acc ← acc ⊕ (multiplicand shifted left j digits, low digits filled with 4'b0011); cnt ← cnt−1.
- RUN, cnt=0:
  - j=NDIG−1 → DONE.
  - Else j ← j+1, cnt ← decoded multiplier digit j+1.
- DONE (1 cycle): out ← acc, done=1, err=0 → IDLE.
- ERR (1 cycle): out ← XS-3 zero, done=1, err=1 → IDLE.
- done/err are registered and high only during the DONE/ERR cycle.
- Latency from the accepting edge to done high:
  - Valid operands: NDIG + Σ(multiplier digits) + 1 cycles.
  - Invalid operands: 1 cycle.
- start while busy is ignored, not queued. start in the DONE/ERR cycle is ignored; a new request is accepted from IDLE on the following cycle.
- XS-3 digit add rule: binary 4-bit sum plus carry-in.
  - Digit carry-out=1 → add 4'b0011.
  - Else → subtract 4'b0011.
  - The carry chains across all 2·NDIG digits.
- acc cannot overflow: the product fits in 2·NDIG digits. The top-digit carry is ignored.
- Multiplier digit 0 consumes only its bookkeeping cycle (cnt=0 at entry).

Decomposition:
- Package e3_pkg:
  - XS3_ZERO = 4'b0011, XS3_MIN = 4'b0011, XS3_MAX = 4'b1100.
  - State enum {IDLE, RUN, DONE, ERR}.
  - Function xs3_valid(digit) → bit.
  - Function xs3_to_int(digit) → 4-bit value.
- Sub-module e3_add, parameter NDIG_ADD: combinational 4·NDIG_ADD-bit XS-3 ripple adder, ports a, b, sum. Instantiated once with NDIG_ADD = 2·NDIG.
- FSM, counters and operand registers live in e3_seq_mult.

Test Plan:
- NDIG=2, in_0=8'h45 (12), in_1=8'h67 (34), start 1 cycle → done after 10 cycles, err=0, out=16'h373B (0408), busy high 10 cycles.
- NDIG=2, in_0=in_1=8'hCC (99) → out=16'hCB34 (9801), done after 21 cycles.
- NDIG=2, in_0=8'h33 (00), in_1=8'h8A (57) → out=16'h3333 after 15 cycles; then in_0=8'h8A, in_1=8'h33 → out=16'h3333 after 3 cycles.
- NDIG=2, in_0=8'h40 (digit 0000 invalid), in_1=8'h44 → done with err=1 one cycle after accept, out=16'h3333; a follow-up valid request completes normally.
- Start pulse while busy (different operands) ignored, first result unaffected. rst_n low mid-RUN → busy=0, done=0, out=16'h3333 asynchronously; no done after release.
- NDIG=1 exhaustive: all 100 valid digit pairs → out equals the 2-digit XS-3 encoding of the decimal product, latency 1+digit(in_1)+1, err=0 throughout.
